// File: rtl/fp_mul_chip.sv
// Byte-serial IEEE 754 binary64 multiplier: loads A then B LSB-first, computes Z = A*B
// with round-to-nearest-even and flush-to-zero, then streams Z out LSB-first.
module fp_mul_chip (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       READY
);

    typedef enum logic [1:0] {StLoad, StCalc, StOut} state_e;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [127:0]  op_q, op_d;
    logic [63:0]   z_q, z_d;

    logic [63:0]   a, b;
    logic          sign_z;
    logic [10:0]   ea, eb;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [105:0]  prod;
    logic [52:0]   kept;
    logic          guard, sticky;
    logic [53:0]   rnd;
    logic signed [13:0] exp_r;
    logic [51:0]   frac_r;
    logic [63:0]   z_calc;

    assign a = op_q[63:0];
    assign b = op_q[127:64];

    always_comb begin
        sign_z = a[63] ^ b[63];
        ea     = a[62:52];
        eb     = b[62:52];
        a_zero = (ea == 11'd0);
        b_zero = (eb == 11'd0);
        a_inf  = (ea == 11'h7FF) && (a[51:0] == 52'd0);
        b_inf  = (eb == 11'h7FF) && (b[51:0] == 52'd0);
        a_nan  = (ea == 11'h7FF) && (a[51:0] != 52'd0);
        b_nan  = (eb == 11'h7FF) && (b[51:0] != 52'd0);

        prod  = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
        exp_r = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 14'sd1023;

        // Product of two [1,2) significands lies in [1,4): normalize on bit 105.
        if (prod[105]) begin
            kept   = prod[105:53];
            guard  = prod[52];
            sticky = |prod[51:0];
            exp_r  = exp_r + 14'sd1;
        end else begin
            kept   = prod[104:52];
            guard  = prod[51];
            sticky = |prod[50:0];
        end

        rnd = {1'b0, kept} + {53'd0, guard & (sticky | kept[0])};
        if (rnd[53]) begin
            frac_r = rnd[52:1];
            exp_r  = exp_r + 14'sd1;
        end else begin
            frac_r = rnd[51:0];
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            z_calc = QNAN;
        end else if (a_inf || b_inf) begin
            z_calc = {sign_z, 11'h7FF, 52'd0};
        end else if (a_zero || b_zero) begin
            z_calc = {sign_z, 63'd0};
        end else if (exp_r >= 14'sd2047) begin
            z_calc = {sign_z, 11'h7FF, 52'd0};
        end else if (exp_r <= 14'sd0) begin
            z_calc = {sign_z, 63'd0};
        end else begin
            z_calc = {sign_z, exp_r[10:0], frac_r};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        z_d     = z_q;
        unique case (state_q)
            StLoad: begin
                if (ENABLE) begin
                    op_d[{cnt_q, 3'b000} +: 8] = DATA_IN;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        state_d = StCalc;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            // Two CALC cycles: latch the result, then enter OUT so READY rises on the 2nd edge.
            StCalc: begin
                if (cnt_q == 4'd0) begin
                    z_d   = z_calc;
                    cnt_d = 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StLoad;
            cnt_q   <= 4'd0;
            op_q    <= 128'd0;
            z_q     <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            z_q     <= z_d;
        end
    end

    assign READY    = (state_q == StOut);
    assign DATA_OUT = READY ? z_q[{cnt_q[2:0], 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_fp_mul_chip.sv
// Self-checking bench for fp_mul_chip: directed IEEE corner cases plus random operands
// compared against the host's binary64 multiply.
module tb_fp_mul_chip;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       ENABLE = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic [7:0] DATA_OUT;
    logic       READY;

    int n_checks = 0;
    int n_errors = 0;

    fp_mul_chip dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .READY    (READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%016h expected=%016h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; drives bytes first..last of {B,A}, optionally with gaps.
    task automatic send_bytes(input logic [127:0] ops, input int first, input int last,
                              input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                repeat ($urandom % 3) begin
                    ENABLE  = 1'b0;
                    DATA_IN = 8'($urandom);
                    @(posedge CLK); #1;
                end
            end
            ENABLE  = 1'b1;
            DATA_IN = ops[i*8 +: 8];
            @(posedge CLK); #1;
        end
        ENABLE  = 1'b0;
        DATA_IN = 8'h00;
    endtask

    // Called #1 after the edge that captured byte 15.
    task automatic collect(input logic [63:0] exp_z, input string tag, input bit pulse,
                           input int abort_at);
        int lat;
        int rlen;
        logic [63:0] z;
        lat = 0;
        while (!READY && lat < 10) begin
            ENABLE  = pulse ? 1'($urandom % 2) : 1'b0;
            DATA_IN = 8'($urandom);
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, ":latency"}, 64'(lat), 64'd2);
        if (!READY) begin
            ENABLE = 1'b0;
            return;
        end
        rlen = 0;
        z    = 64'd0;
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                RESET  = 1'b0;
                ENABLE = 1'b0;
                @(posedge CLK); #1;
                check({tag, ":abort_ready"}, 64'(READY), 64'd0);
                check({tag, ":abort_dout"}, 64'(DATA_OUT), 64'd0);
                RESET = 1'b1;
                return;
            end
            if (READY) rlen++;
            z[k*8 +: 8] = DATA_OUT;
            ENABLE  = (pulse && k < 7) ? 1'($urandom % 2) : 1'b0;
            DATA_IN = 8'($urandom);
            @(posedge CLK); #1;
        end
        ENABLE = 1'b0;
        check({tag, ":ready_len"}, 64'(rlen), 64'd8);
        check({tag, ":z"}, z, exp_z);
        check({tag, ":ready_low"}, 64'(READY), 64'd0);
        check({tag, ":dout_idle"}, 64'(DATA_OUT), 64'd0);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_z,
                          input string tag, input bit gaps, input bit pulse);
        send_bytes({b, a}, 0, 15, gaps);
        collect(exp_z, tag, pulse, -1);
    endtask

    initial begin
        int n1, d1, n2, d2;
        real ra, rb;
        logic [63:0] a, b;

        RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ready", 64'(READY), 64'd0);
        check("reset_dout", 64'(DATA_OUT), 64'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;

        run_op(64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, "mul_1p5x2", 0, 0);
        run_op(64'hBFF0000000000000, 64'h3FE0000000000000, 64'hBFE0000000000000, "neg_half", 0, 0);
        run_op(64'h0000000000000000, 64'h4008000000000000, 64'h0000000000000000, "zero_a", 0, 0);
        run_op(64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, "sticky", 0, 0);
        run_op(64'h7FE0000000000000, 64'h4000000000000000, 64'h7FF0000000000000, "overflow", 0, 0);
        run_op(64'h0010000000000000, 64'h3FE0000000000000, 64'h0000000000000000, "underflow", 0, 0);
        run_op(64'h0000000000000001, 64'hBFF0000000000000, 64'h8000000000000000, "subnorm", 0, 0);
        run_op(64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, "nan_in", 0, 0);
        run_op(64'hFFF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, "inf_x_0", 0, 0);
        run_op(64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, "ninf_x2", 0, 0);

        run_op(64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, "gaps", 1, 0);
        run_op(64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, "pulse", 0, 1);

        // Abort mid-load after byte 5, then a full fresh load.
        send_bytes({64'h4000000000000000, 64'h3FF8000000000000}, 0, 5, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("rst_load_ready", 64'(READY), 64'd0);
        check("rst_load_dout", 64'(DATA_OUT), 64'd0);
        RESET = 1'b1;
        run_op(64'hBFF0000000000000, 64'h3FE0000000000000, 64'hBFE0000000000000, "after_rst_load",
               0, 0);

        // Abort in the third READY cycle.
        send_bytes({64'h4000000000000000, 64'h3FF8000000000000}, 0, 15, 0);
        collect(64'h4008000000000000, "rst_out", 0, 2);
        run_op(64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002, "after_rst_out",
               0, 0);

        for (int i = 0; i < 200; i++) begin
            n1 = int'($urandom);
            d1 = int'($urandom);
            n2 = int'($urandom);
            d2 = int'($urandom);
            if (d1 == 0) d1 = 1;
            if (d2 == 0) d2 = 1;
            ra = real'(n1) / real'(d1);
            rb = real'(n2) / real'(d2);
            a  = $realtobits(ra);
            b  = $realtobits(rb);
            run_op(a, b, $realtobits(ra * rb), $sformatf("rand%0d", i), (i % 4) == 1,
                   (i % 5) == 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_chip.md
FP_MUL_CHIP -- requirements
Module: fp_mul_chip

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports SHALL be named as below.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 ENABLE  input  1  high = DATA_IN carries a valid operand byte this cycle.
REQ-005 DATA_IN  input  8  operand byte stream.
REQ-006 DATA_OUT  output  8  result byte stream, valid while READY=1, else 8'h00.
REQ-007 READY  output  1  high for exactly 8 consecutive cycles while result bytes are presented.

Function
REQ-008 The block SHALL compute Z = A * B for IEEE 754 binary64 operands A and B, using round-to-nearest-even.
REQ-009 State machine states: LOAD, CALC, OUT.
- LOAD: one byte captured per rising edge with ENABLE=1.
- LOAD: ENABLE=0 cycles hold the byte counter, so gaps are allowed.
REQ-010 Capture order: 16 bytes total, least-significant byte first.
- Bytes 0-7 = A[7:0] ... A[63:56].
- Bytes 8-15 = B[7:0] ... B[63:56].
REQ-011 Capture of byte 15 SHALL move the block LOAD -> CALC; ENABLE SHALL be ignored in CALC and OUT.
REQ-012 Latency: READY SHALL rise at the second rising edge after the edge that captured byte 15.
REQ-013 OUT phase:
- DATA_OUT SHALL carry Z[7:0] in the first READY cycle, Z[15:8] in the second, ... Z[63:56] in the eighth.
- After the eighth cycle, READY=0, DATA_OUT=0, state LOAD, counter 0.
REQ-014 READY SHALL be low for at least one cycle between results, so every result produces a new rising edge.
REQ-015 Sign: Z sign = A sign XOR B sign, in all cases including zero and infinity.
REQ-016 Normal path:
- 53x53-bit significand product (106 bits), exponent = eA + eB - 1023.
- Normalize by one position if product >= 2.
- Round with guard bit plus OR-of-remaining sticky, ties to even.
- Renormalize if rounding carries out.
REQ-017 Zero/subnormal inputs: an operand with exponent field 0 SHALL be treated as zero; if the other operand is finite, Z = signed zero.
REQ-018 Overflow: a biased result exponent >= 2047 after rounding SHALL give signed infinity (exp 7FF, fraction 0).
REQ-019 Underflow: a biased result exponent <= 0 SHALL give signed zero (flush to zero, no subnormal outputs).
REQ-020 Special operands:
- Any NaN operand, or infinity * zero, SHALL give 64'h7FF8000000000000.
- Infinity * nonzero finite SHALL give signed infinity.
REQ-021 Implementation may be multi-cycle internally only if the REQ-012 latency is preserved exactly.

Reset
REQ-022 While RESET=0 at a rising edge:
- State = LOAD, byte counter = 0, operand registers = 0.
- READY = 0, DATA_OUT = 8'h00.
REQ-023 Reset asserted in LOAD, CALC or OUT SHALL abort the operation; the next ENABLE byte after release SHALL be treated as A byte 0.

Verification
REQ-024 A=3FF8000000000000 (1.5), B=4000000000000000 (2.0) -> READY exactly 2 edges after last byte, then 8 bytes forming Z=4008000000000000.
REQ-025 A=BFF0000000000000, B=3FE0000000000000 -> Z=BFE0000000000000; A=0, B=4008000000000000 -> Z=0000000000000000.
REQ-026 A=B=3FF0000000000001 -> Z=3FF0000000000002 (sticky rounds down); A=7FE0000000000000, B=4000000000000000 -> Z=7FF0000000000000.
REQ-027 ENABLE toggled low between operand bytes -> same Z as contiguous load; ENABLE pulsed during CALC/OUT -> ignored, result unchanged.
REQ-028 RESET=0 in mid-load (after byte 5) and in mid-OUT (third READY cycle) -> READY and DATA_OUT drop to 0 next edge; a full fresh 16-byte load then gives the correct Z.
REQ-029 Back-to-back: 200 random operand pairs (ratios of random 32-bit integers, both signs) -> every Z bit-exact with host binary64 multiply.
